// File: rtl/tmac_seq_ctrl_if.sv
// Handshake and datapath-control bundle between the job host, the
// sequencing controller and the stochastic MAC array.
// Optional macro TMAC_CTRL_PROG_LEN_EN adds the cfg_log2len field.
interface tmac_seq_ctrl_if #(
  parameter int BW    = 8,
  parameter int CNT_W = BW + 1
);
  logic             in_valid;
  logic             in_ready;
  logic             abort;
  logic             load_a;
  logic             load_b;
  logic             rng_clr;
  logic             rng_en;
  logic             mac_bit;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] out_result;
  logic             busy;
`ifdef TMAC_CTRL_PROG_LEN_EN
  logic [$clog2(BW+1)-1:0] cfg_log2len;
`endif

  // Host / datapath side: issues jobs, feeds mac_bit, consumes results
  modport master (
`ifdef TMAC_CTRL_PROG_LEN_EN
    output cfg_log2len,
`endif
    output in_valid, abort, mac_bit, out_ready,
    input  in_ready, load_a, load_b, rng_clr, rng_en,
    input  out_valid, out_result, busy
  );

  // Controller side
  modport slave (
`ifdef TMAC_CTRL_PROG_LEN_EN
    input  cfg_log2len,
`endif
    input  in_valid, abort, mac_bit, out_ready,
    output in_ready, load_a, load_b, rng_clr, rng_en,
    output out_valid, out_result, busy
  );
endinterface

// File: rtl/tmac_seq_ctrl.sv
// Sequencing controller for the 16-lane unipolar stochastic MAC array.
// Accepts a job, pulses operand loads and the RNG clear, runs the Sobol
// bitstream for a full period, counts the delayed MAC output stream and
// returns the count through a valid/ready handshake.
// Optional macro TMAC_CTRL_PROG_LEN_EN: programmable run length 2^L,
// L sampled from cfg_log2len on accept and clamped to
// [ceil(log2(PIPE_LAT)), BW]; the result is rescaled to the 2^BW range.
module tmac_seq_ctrl #(
  parameter int BW       = 8,
  parameter int PIPE_LAT = 3,
  parameter int CNT_W    = BW + 1
) (
  input logic            clk,
  input logic            rst,
  tmac_seq_ctrl_if.slave bus
);

  localparam int DCNT_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             state_reg;
  state_t             state_next;
  logic [BW-1:0]      cyc_reg;
  logic [DCNT_W-1:0]  dcnt_reg;
  logic [CNT_W-1:0]   acc_reg;

  logic [BW-1:0]      run_last;
  logic [CNT_W-1:0]   result_scaled;
  logic               accept;
  logic               acc_en;
  logic               run_done;
  logic               drain_done;

  logic               in_ready_c;
  logic               load_c;
  logic               rng_en_c;
  logic               out_valid_c;
  logic               busy_c;

`ifdef TMAC_CTRL_PROG_LEN_EN
  localparam int LEN_W = $clog2(BW + 1);
  localparam int LMIN  = $clog2(PIPE_LAT);

  logic [LEN_W-1:0] len_reg;
  logic [LEN_W-1:0] len_clamped;
  logic [CNT_W-1:0] run_len;

  // Clamp the requested log2 length so the window still covers the pipeline
  always_comb begin
    len_clamped = bus.cfg_log2len;
    if (bus.cfg_log2len < LEN_W'(LMIN)) begin
      len_clamped = LEN_W'(LMIN);
    end else if (bus.cfg_log2len > LEN_W'(BW)) begin
      len_clamped = LEN_W'(BW);
    end
  end

  // Run length is captured with the job and held for its duration
  always_ff @(posedge clk) begin
    if (rst) begin
      len_reg <= LEN_W'(BW);
    end else if (accept) begin
      len_reg <= len_clamped;
    end
  end

  assign run_len       = CNT_W'(1) << len_reg;
  assign run_last      = BW'(run_len - CNT_W'(1));
  assign result_scaled = acc_reg << (LEN_W'(BW) - len_reg);
`else
  assign run_last      = '1;
  assign result_scaled = acc_reg;
`endif

  assign accept     = (state_reg == S_IDLE) && bus.in_valid && !bus.abort;
  assign run_done   = (cyc_reg == run_last);
  assign drain_done = (dcnt_reg == DCNT_W'(PIPE_LAT - 1));
  // The first PIPE_LAT RUN samples belong to the previous job's pipeline
  // contents; DRAIN supplies the tail so the window is exactly 2^L long.
  assign acc_en     = ((state_reg == S_RUN) &&
                       ({1'b0, cyc_reg} >= CNT_W'(PIPE_LAT))) ||
                      (state_reg == S_DRAIN);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and per-state control outputs
  always_comb begin
    state_next  = state_reg;
    in_ready_c  = 1'b0;
    load_c      = 1'b0;
    rng_en_c    = 1'b0;
    out_valid_c = 1'b0;
    busy_c      = 1'b0;
    case (state_reg)
      S_IDLE: begin
        in_ready_c = !bus.abort;
        if (bus.in_valid && !bus.abort) begin
          state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        load_c     = 1'b1;
        busy_c     = 1'b1;
        state_next = bus.abort ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        rng_en_c = 1'b1;
        busy_c   = 1'b1;
        if (bus.abort) begin
          state_next = S_IDLE;
        end else if (run_done) begin
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        rng_en_c = 1'b1;
        busy_c   = 1'b1;
        if (bus.abort || drain_done) begin
          state_next = bus.abort ? S_IDLE : S_DONE;
        end
      end
      S_DONE: begin
        out_valid_c = 1'b1;
        busy_c      = 1'b1;
        if (bus.abort || bus.out_ready) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // RUN cycle counter and DRAIN counter, each zero outside its own state
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_reg  <= '0;
      dcnt_reg <= '0;
    end else begin
      cyc_reg  <= (state_reg == S_RUN)   ? cyc_reg + BW'(1)      : '0;
      dcnt_reg <= (state_reg == S_DRAIN) ? dcnt_reg + DCNT_W'(1) : '0;
    end
  end

  // Ones counter over the accumulation window, cleared on accept
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg <= '0;
    end else if (accept) begin
      acc_reg <= '0;
    end else if (acc_en && bus.mac_bit) begin
      acc_reg <= acc_reg + CNT_W'(1);
    end
  end

  // Every output is forced low while reset is held
  assign bus.in_ready   = in_ready_c  && !rst;
  assign bus.load_a     = load_c      && !rst;
  assign bus.load_b     = load_c      && !rst;
  assign bus.rng_clr    = load_c      && !rst;
  assign bus.rng_en     = rng_en_c    && !rst;
  assign bus.out_valid  = out_valid_c && !rst;
  assign bus.busy       = busy_c      && !rst;
  assign bus.out_result = (out_valid_c && !rst) ? result_scaled : '0;

endmodule

// File: tb/tb_tmac_seq_ctrl.sv
// Bench for tmac_seq_ctrl: a timeline model (cycles since accept) predicts
// every output each cycle; directed jobs add literal latency/result checks.
// Optional macro TMAC_CTRL_PROG_LEN_EN enables the programmable-length jobs.
module tb_tmac_seq_ctrl;
  localparam int BW    = 8;
  localparam int P     = 3;
  localparam int CNT_W = BW + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tmac_seq_ctrl_if #(.BW(BW), .CNT_W(CNT_W)) bus ();

  tmac_seq_ctrl #(.BW(BW), .PIPE_LAT(P), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int vectors     = 0;
  int miscompares = 0;
  bit cmp_en      = 1'b0;
  int mode_r      = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Timeline model: a job is "cycles since accept"; k=1 is the load cycle
  logic m_active = 1'b0;
  int   m_k      = 0;
  int   m_acc    = 0;
  int   m_len    = BW;

  function automatic int clamp_len(input int c);
    if (c < 2)  return 2;   // ceil(log2(3))
    if (c > BW) return BW;
    return c;
  endfunction

  function automatic int done_k(input int len);
    return 2 + (1 << len) + P;
  endfunction

  function automatic logic pat(input int mode, input int k, input logic act);
    if (!act) return 1'b0;
    case (mode)
      1:       return 1'b1;
      2:       return (k >= 2 && k <= 4);   // RUN cycles 0..2 only
      3:       return k[0];
      default: return 1'b0;
    endcase
  endfunction

  // Model update on each active edge
  always @(posedge clk) begin
    if (rst) begin
      m_active <= 1'b0;
      m_k      <= 0;
      m_acc    <= 0;
    end else if (!m_active) begin
      if (bus.in_valid && !bus.abort) begin
        m_active <= 1'b1;
        m_k      <= 1;
        m_acc    <= 0;
`ifdef TMAC_CTRL_PROG_LEN_EN
        m_len    <= clamp_len(int'(bus.cfg_log2len));
`else
        m_len    <= BW;
`endif
      end
    end else if (bus.abort) begin
      m_active <= 1'b0;
    end else if (m_k == done_k(m_len)) begin
      if (bus.out_ready) m_active <= 1'b0;
    end else begin
      if (m_k >= 2 + P && bus.mac_bit) m_acc <= m_acc + 1;
      m_k <= m_k + 1;
    end
  end

  // Compare process: every output, every cycle, at the falling edge
  always @(negedge clk) begin
    if (cmp_en) begin
      logic act, ov;
      act = !rst && m_active;
      ov  = act && (m_k == done_k(m_len));
      check("in_ready",   bus.in_ready,   !rst && !m_active && !bus.abort);
      check("load_a",     bus.load_a,     act && m_k == 1);
      check("load_b",     bus.load_b,     act && m_k == 1);
      check("rng_clr",    bus.rng_clr,    act && m_k == 1);
      check("rng_en",     bus.rng_en,     act && m_k >= 2 && m_k < done_k(m_len));
      check("out_valid",  bus.out_valid,  ov);
      check("out_result", bus.out_result, ov ? (m_acc << (BW - m_len)) : 0);
      check("busy",       bus.busy,       act);
    end
  end

  int t;

  task automatic step();
    @(posedge clk);
    #1;
    bus.mac_bit = pat(mode_r, m_k, m_active);
    t++;
  endtask

  task automatic start_job(input int mode, input int cfg);
    mode_r = mode;
    check("in_ready_pre", bus.in_ready, 1);
    bus.in_valid = 1'b1;
`ifdef TMAC_CTRL_PROG_LEN_EN
    bus.cfg_log2len = ($clog2(BW+1))'(cfg);
`else
    if (cfg != BW) $display("note: cfg %0d ignored without programmable length", cfg);
`endif
    step();
    bus.in_valid = 1'b0;
    t = 1;
  endtask

  task automatic run_job(input int mode, input int cfg, input int exp_res,
                         input int exp_lat, input int bp);
    int en_cnt;
    bus.out_ready = (bp == 0);
    start_job(mode, cfg);
    check("load_a_T+1", bus.load_a, 1);
    check("load_b_T+1", bus.load_b, 1);
    en_cnt = 0;
    while (!bus.out_valid && t < 2000) begin
      step();
      if (bus.rng_en) en_cnt++;
    end
    check("latency", t, exp_lat);
    check("result", bus.out_result, exp_res);
    check("rng_en_cycles", en_cnt, exp_lat - 2);
    for (int i = 0; i < bp; i++) begin
      step();
      check("bp_result", bus.out_result, exp_res);
      check("bp_busy", bus.busy, 1);
    end
    bus.out_ready = 1'b1;
    step();
    check("idle_after", bus.busy, 0);
    check("in_ready_after", bus.in_ready, 1);
    $display("job mode=%0d cfg=%0d result=%0d latency=%0d bp=%0d", mode, cfg, exp_res, exp_lat, bp);
  endtask

  initial begin
    bool_init();
    step(); step(); step();
    cmp_en = 1'b1;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_busy", bus.busy, 0);
    rst = 1'b0;
    step();

    run_job(1, BW, 256, 261, 0);
    run_job(0, BW, 0,   261, 0);
    run_job(2, BW, 0,   261, 0);
    run_job(3, BW, 128, 261, 0);
    run_job(1, BW, 256, 261, 10);

    // Abort at RUN cyc = 100
    bus.out_ready = 1'b1;
    start_job(1, BW);
    while (t < 102) step();
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check("abort_busy", bus.busy, 0);
    check("abort_rng_en", bus.rng_en, 0);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 300; i++) begin
        step();
        if (bus.out_valid) seen = 1'b1;
      end
      check("abort_no_valid", seen, 0);
    end
    $display("job aborted at RUN cyc 100");
    run_job(1, BW, 256, 261, 0);

    // Abort in IDLE wins over in_valid
    bus.abort = 1'b1;
    bus.in_valid = 1'b1;
    #1;
    check("idle_abort_in_ready", bus.in_ready, 0);
    step();
    bus.abort = 1'b0;
    bus.in_valid = 1'b0;
    check("idle_abort_busy", bus.busy, 0);
    $display("abort with in_valid in IDLE: not accepted");
    step();

    // Reset mid-job
    start_job(1, BW);
    while (t < 50) step();
    rst = 1'b1;
    #1;
    check("midrst_busy", bus.busy, 0);
    check("midrst_rng_en", bus.rng_en, 0);
    step();
    rst = 1'b0;
    step();
    check("midrst_in_ready", bus.in_ready, 1);
    $display("reset mid-job returns to idle");

`ifdef TMAC_CTRL_PROG_LEN_EN
    run_job(1, 4,  256, 21,  0);
    run_job(3, 4,  128, 21,  0);
    run_job(1, 15, 256, 261, 0);
    run_job(1, 0,  256, 9,   0);
`endif

    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  task automatic bool_init();
    bus.in_valid  = 1'b0;
    bus.abort     = 1'b0;
    bus.mac_bit   = 1'b0;
    bus.out_ready = 1'b1;
`ifdef TMAC_CTRL_PROG_LEN_EN
    bus.cfg_log2len = ($clog2(BW+1))'(BW);
`endif
    t = 0;
  endtask

endmodule
